// File: rtl/ibexc_data_mem_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : ibexc_data_mem_resp_if
// Description : CHERIoT core data-bus bundle (req/gnt/rvalid, 33-bit tagged data).
// Revision    : 1.0 - initial release
// ============================================================================
interface ibexc_data_mem_resp_if;
    logic        data_req_i;
    logic        data_is_cap_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [32:0] data_wdata_i;
    logic        stall_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [32:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_is_cap_i, data_we_i, data_be_i, data_addr_i,
               data_wdata_i, stall_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_is_cap_i, data_we_i, data_be_i, data_addr_i,
               data_wdata_i, stall_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface
`default_nettype wire

// File: rtl/ibexc_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : ibexc_data_mem_resp
// Description : Fixed-latency tagged SRAM responder for the CHERIoT data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module ibexc_data_mem_resp #(
    parameter logic [31:0] AddrBase = 32'h2000_0000,
    parameter int          MemWords = 4096,
    parameter int          Latency  = 1
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    ibexc_data_mem_resp_if.slave bus
);

    localparam int          IDX_W     = $clog2(MemWords);
    localparam logic [33:0] WIN_BYTES = 34'(MemWords) << 2;

    logic [31:0]      addr_off;
    logic             hit;
    logic             acc_err;
    logic             gnt;
    logic             wr_en;
    logic             wr_tag;
    logic [IDX_W-1:0] idx;
    logic [32:0]      rd_word;
    logic [32:0]      resp_rdata;

    logic [32:0] mem [MemWords];

    logic [Latency-1:0] valid_d, valid_q;
    logic [Latency-1:0] err_d,   err_q;
    logic [32:0]        rdata_d [Latency];
    logic [32:0]        rdata_q [Latency];

    always_comb begin
        // Unsigned compare on the raw address keeps high addresses from wrapping into the window.
        addr_off = bus.data_addr_i - AddrBase;
        hit      = (bus.data_addr_i >= AddrBase) && ({2'b00, addr_off} < WIN_BYTES);
        idx      = addr_off[IDX_W+1:2];
        acc_err  = !hit
                 || (bus.data_is_cap_i && (bus.data_addr_i[1:0] != 2'b00))
                 || (bus.data_is_cap_i && (bus.data_be_i != 4'hF));
        gnt      = bus.data_req_i && !bus.stall_i && !rst_i;
        wr_en    = gnt && bus.data_we_i && !acc_err;
        wr_tag   = bus.data_is_cap_i && (bus.data_be_i == 4'hF) && bus.data_wdata_i[32];
        rd_word  = mem[idx];

        resp_rdata = 33'd0;
        if (!acc_err && !bus.data_we_i) begin
            resp_rdata = {bus.data_is_cap_i && rd_word[32], rd_word[31:0]};
        end
    end

    // Array is deliberately not reset; any non-capability store clears the tag.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
            mem[idx][32] <= wr_tag;
        end
    end

    always_comb begin
        valid_d[0] = gnt;
        err_d[0]   = gnt && acc_err;
        rdata_d[0] = gnt ? resp_rdata : 33'd0;
        for (int i = 1; i < Latency; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            rdata_d[i] = rdata_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < Latency; i++) begin
                rdata_q[i] <= 33'd0;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int i = 0; i < Latency; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = valid_q[Latency-1];
    assign bus.data_err_o    = err_q[Latency-1];
    assign bus.data_rdata_o  = rdata_q[Latency-1];

endmodule
`default_nettype wire

// File: tb/tb_ibexc_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibexc_data_mem_resp
// Description : Self-checking bench; three responders (Latency 1/3/4) share one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibexc_data_mem_resp;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          WORDS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, cap = 1'b0, we = 1'b0, stall = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'd0;
    logic [32:0] wdata = 33'd0;
    logic [32:0] cur_exp_rdata = 33'd0;
    logic        cur_exp_err = 1'b0;

    always #5 clk = ~clk;

    ibexc_data_mem_resp_if bus0 ();
    ibexc_data_mem_resp_if bus1 ();
    ibexc_data_mem_resp_if bus2 ();

    assign bus0.data_req_i = req;   assign bus1.data_req_i = req;   assign bus2.data_req_i = req;
    assign bus0.data_is_cap_i = cap; assign bus1.data_is_cap_i = cap; assign bus2.data_is_cap_i = cap;
    assign bus0.data_we_i = we;     assign bus1.data_we_i = we;     assign bus2.data_we_i = we;
    assign bus0.data_be_i = be;     assign bus1.data_be_i = be;     assign bus2.data_be_i = be;
    assign bus0.data_addr_i = addr; assign bus1.data_addr_i = addr; assign bus2.data_addr_i = addr;
    assign bus0.data_wdata_i = wdata; assign bus1.data_wdata_i = wdata; assign bus2.data_wdata_i = wdata;
    assign bus0.stall_i = stall;    assign bus1.stall_i = stall;    assign bus2.stall_i = stall;

    ibexc_data_mem_resp #(.AddrBase(BASE), .MemWords(WORDS), .Latency(1)) u_dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    ibexc_data_mem_resp #(.AddrBase(BASE), .MemWords(WORDS), .Latency(3)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    ibexc_data_mem_resp #(.AddrBase(BASE), .MemWords(WORDS), .Latency(4)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    logic [2:0]  dut_gnt, dut_rv, dut_err;
    logic [32:0] dut_rdata [3];
    assign dut_gnt = {bus2.data_gnt_o, bus1.data_gnt_o, bus0.data_gnt_o};
    assign dut_rv  = {bus2.data_rvalid_o, bus1.data_rvalid_o, bus0.data_rvalid_o};
    assign dut_err = {bus2.data_err_o, bus1.data_err_o, bus0.data_err_o};
    assign dut_rdata[0] = bus0.data_rdata_o;
    assign dut_rdata[1] = bus1.data_rdata_o;
    assign dut_rdata[2] = bus2.data_rdata_o;

    typedef struct {
        logic        we;
        logic        cap;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [32:0] wdata;
        int          stall_cyc;
        logic [32:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [32:0] rdata;
        logic        err;
        int          cyc;
    } sb_t;

    sb_t issued [512];
    int  wr_ptr = 0;
    int  rd_ptr [3] = '{0, 0, 0};
    int  cyc = 0;
    bit  mon_en = 1'b0;
    int  tests = 0;
    int  fails = 0;

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 4;
    endfunction

    task automatic check(string name, logic [32:0] act, logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each grant logs its expected response; each responder retires it Latency cycles later.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_gnt;
            exp_gnt = req && !stall && !rst;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("dut%0d gnt", i), 33'(dut_gnt[i]), 33'(exp_gnt));
                if (rst) begin
                    rd_ptr[i] = wr_ptr;
                end else if (rd_ptr[i] < wr_ptr && issued[rd_ptr[i]].cyc + lat_of(i) == cyc) begin
                    check($sformatf("dut%0d rvalid", i), 33'(dut_rv[i]), 33'd1);
                    check($sformatf("dut%0d rdata", i), dut_rdata[i], issued[rd_ptr[i]].rdata);
                    check($sformatf("dut%0d err", i), 33'(dut_err[i]), 33'(issued[rd_ptr[i]].err));
                    rd_ptr[i]++;
                end else begin
                    check($sformatf("dut%0d idle rvalid", i), 33'(dut_rv[i]), 33'd0);
                end
            end
            if (exp_gnt) begin
                issued[wr_ptr] = '{rdata: cur_exp_rdata, err: cur_exp_err, cyc: cyc};
                wr_ptr++;
            end
        end
    end

    task automatic drive(vec_t v);
        req = 1'b1; we = v.we; cap = v.cap; be = v.be; addr = v.addr; wdata = v.wdata;
        cur_exp_rdata = v.exp_rdata; cur_exp_err = v.exp_err;
        stall = (v.stall_cyc != 0);
        repeat (v.stall_cyc) begin @(posedge clk); #1; end
        stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        req = 1'b0; stall = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    vec_t vecs [21];

    initial begin
        //            we    cap   be     addr           wdata           stall exp_rdata        err
        vecs[0]  = '{1'b1, 1'b1, 4'hF, BASE,          33'h1_DEADBEEF, 0, 33'h0,           1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'hF, BASE,          33'h0,          0, 33'h1_DEADBEEF,  1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'h1, BASE,          33'h0_000000AA, 2, 33'h0,           1'b0};
        vecs[3]  = '{1'b0, 1'b1, 4'hF, BASE,          33'h0,          0, 33'h0_DEADBEAA,  1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'hF, BASE + 4,      33'h1_12345678, 0, 33'h0,           1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h1, BASE + 4,      33'h0,          0, 33'h0_12345678,  1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'hF, BASE + 4,      33'h0,          1, 33'h1_12345678,  1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'hF, BASE + 256,    33'h0,          0, 33'h0,           1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'hF, BASE + 2,      33'h0,          0, 33'h0,           1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'hF, BASE + 2,      33'h1_FFFFFFFF, 0, 33'h0,           1'b1};
        vecs[10] = '{1'b1, 1'b1, 4'h3, BASE + 4,      33'h1_FFFFFFFF, 0, 33'h0,           1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'hF, 32'hFFFF_FFFC, 33'h0_FFFFFFFF, 0, 33'h0,           1'b1};
        vecs[12] = '{1'b0, 1'b0, 4'hF, 32'h1FFF_FFFC, 33'h0,          0, 33'h0,           1'b1};
        vecs[13] = '{1'b0, 1'b1, 4'hF, BASE,          33'h0,          0, 33'h0_DEADBEAA,  1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'hF, BASE + 4,      33'h0,          0, 33'h1_12345678,  1'b0};
        vecs[15] = '{1'b1, 1'b0, 4'hF, BASE + 4,      33'h1_CAFEF00D, 0, 33'h0,           1'b0};
        vecs[16] = '{1'b0, 1'b1, 4'hF, BASE + 4,      33'h0,          0, 33'h0_CAFEF00D,  1'b0};
        vecs[17] = '{1'b1, 1'b1, 4'hF, BASE + 252,    33'h1_0BADF00D, 0, 33'h0,           1'b0};
        vecs[18] = '{1'b0, 1'b1, 4'hF, BASE + 252,    33'h0,          0, 33'h1_0BADF00D,  1'b0};
        vecs[19] = '{1'b1, 1'b0, 4'hA, BASE + 252,    33'h0_11223344, 0, 33'h0,           1'b0};
        vecs[20] = '{1'b0, 1'b1, 4'hF, BASE + 252,    33'h0,          0, 33'h0_11AD330D,  1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d reset rvalid", i), 33'(dut_rv[i]), 33'd0);
            check($sformatf("dut%0d reset err", i), 33'(dut_err[i]), 33'd0);
            check($sformatf("dut%0d reset rdata", i), dut_rdata[i], 33'd0);
        end
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 21; v++) drive(vecs[v]);
        idle(6);

        // Five back-to-back grants, then a stalled request that must never be granted.
        drive('{1'b0, 1'b1, 4'hF, BASE,       33'h0, 0, 33'h0_DEADBEAA, 1'b0});
        drive('{1'b0, 1'b1, 4'hF, BASE + 4,   33'h0, 0, 33'h0_CAFEF00D, 1'b0});
        drive('{1'b0, 1'b0, 4'hF, BASE + 252, 33'h0, 0, 33'h0_11AD330D, 1'b0});
        drive('{1'b0, 1'b0, 4'hF, BASE + 256, 33'h0, 0, 33'h0,          1'b1});
        drive('{1'b0, 1'b0, 4'h1, BASE,       33'h0, 0, 33'h0_DEADBEAA, 1'b0});
        req = 1'b1; stall = 1'b1; we = 1'b0; cap = 1'b0; addr = BASE;
        repeat (3) begin @(posedge clk); #1; end
        idle(8);

        // Two loads in flight, reset with a request held, request serviced after reset.
        drive('{1'b0, 1'b1, 4'hF, BASE,     33'h0, 0, 33'h0_DEADBEAA, 1'b0});
        drive('{1'b0, 1'b1, 4'hF, BASE + 4, 33'h0, 0, 33'h0_CAFEF00D, 1'b0});
        req = 1'b1; stall = 1'b0; we = 1'b0; cap = 1'b1; be = 4'hF; addr = BASE + 252;
        cur_exp_rdata = 33'h0_11AD330D; cur_exp_err = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        idle(8);

        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d drained", i), 33'(rd_ptr[i]), 33'(wr_ptr));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
